// File: rtl/vga_ctrl_if.sv
// vga_ctrl_if: pixel coordinate request and colour return path
// between the VGA timing generator and the pattern generator.
interface vga_ctrl_if;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_data_req;
    logic [11:0] pix_data;

    modport master (
        output pix_x,
        output pix_y,
        output pix_data_req,
        input  pix_data
    );

    modport slave (
        input  pix_x,
        input  pix_y,
        input  pix_data_req,
        output pix_data
    );
endinterface

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing generator and blanking output stage.
// All outputs decode combinationally from the two position counters.
module vga_ctrl #(
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   H_VALID     = 640,
    parameter int   H_FRONT     = 16,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter int   V_VALID     = 480,
    parameter int   V_FRONT     = 10,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    vga_ctrl_if.master  pix,
    output logic        rgb_valid,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam logic [9:0] H_TOTAL = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT);
    localparam logic [9:0] V_TOTAL = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT);
    localparam logic [9:0] H_LAST  = H_TOTAL - 10'd1;
    localparam logic [9:0] V_LAST  = V_TOTAL - 10'd1;
    localparam logic [9:0] H_SYN_E = 10'(H_SYNC);
    localparam logic [9:0] V_SYN_E = 10'(V_SYNC);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_VALID);
    // Request window runs one clock ahead of the visible window
    localparam logic [9:0] H_REQ_S = H_START - 10'd1;
    localparam logic [9:0] H_REQ_E = H_END - 10'd1;

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       h_vis;
    logic       h_req;
    logic       v_vis;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h <= 10'd0;
            cnt_v <= 10'd0;
        end else if (cnt_h == H_LAST) begin
            cnt_h <= 10'd0;
            if (cnt_v == V_LAST)
                cnt_v <= 10'd0;
            else
                cnt_v <= cnt_v + 10'd1;
        end else begin
            cnt_h <= cnt_h + 10'd1;
        end
    end

    always_comb begin
        h_vis = (cnt_h >= H_START) && (cnt_h < H_END);
        h_req = (cnt_h >= H_REQ_S) && (cnt_h < H_REQ_E);
        v_vis = (cnt_v >= V_START) && (cnt_v < V_END);
    end

    always_comb begin
        hsync            = (cnt_h < H_SYN_E) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync            = (cnt_v < V_SYN_E) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        rgb_valid        = h_vis && v_vis;
        pix.pix_data_req = h_req && v_vis;
        frame_start      = (cnt_h == 10'd0) && (cnt_v == 10'd0);
    end

    always_comb begin
        pix.pix_x = 10'h3FF;
        pix.pix_y = 10'h3FF;
        if (pix.pix_data_req) begin
            pix.pix_x = cnt_h - H_REQ_S;
            pix.pix_y = cnt_v - V_START;
        end
    end

    // Blank unconditionally outside the visible window
    always_comb begin
        rgb = rgb_valid ? pix.pix_data : 12'h000;
    end

endmodule
